clk_div_bank: RTL and testbench

Parametrised, multi-channel successor to the single fixed-ratio clock divider. One `clk_in` domain drives `CHANNELS` independent divider channels. Each channel has a run-time programmable divisor, a per-channel enable, a 50 % duty divided output, and a one-cycle rising-edge tick strobe. The block sits at the top level and generates slow clocks and strobes for FSMs, debouncers and display scanning. The divisor is loaded over a valid/ready port.

---
 rtl/clk_div_bank.sv | 106 ++++++++++
 tb/tb_clk_div_bank.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of programmable 50% duty clock dividers with tick strobes.
// Define CLK_DIV_BANK_SYNC_LOAD_EN for glitch-free divisor loads at terminal count.
module clk_div_bank #(
  parameter int              CHANNELS    = 4,
  parameter int              WIDTH       = 32,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(2499999)
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
  input  logic [WIDTH-1:0]    cfg_div,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [WIDTH-1:0]    count   [CHANNELS];
  logic [WIDTH-1:0]    div_act [CHANNELS];
  logic [CHANNELS-1:0] hit;

`ifdef CLK_DIV_BANK_SYNC_LOAD_EN
  logic [WIDTH-1:0]    div_shadow [CHANNELS];
  logic [CHANNELS-1:0] pending;

  // Out-of-range channels stay ready so the write is silently dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CW'(i)) cfg_ready = ~pending[i];
    end
  end
`else
  always_comb cfg_ready = 1'b1;
`endif

  always_comb begin
    hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hit[i] = cfg_valid && cfg_ready && (cfg_chan == CW'(i));
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      clk_out <= '0;
      tick    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        count[i]   <= '0;
        div_act[i] <= DEFAULT_DIV;
      end
`ifdef CLK_DIV_BANK_SYNC_LOAD_EN
      pending <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        div_shadow[i] <= DEFAULT_DIV;
      end
`endif
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        tick[i] <= 1'b0;
`ifdef CLK_DIV_BANK_SYNC_LOAD_EN
        if (en[i]) begin
          if (count[i] == div_act[i]) begin
            count[i]   <= '0;
            clk_out[i] <= ~clk_out[i];
            tick[i]    <= ~clk_out[i];
            if (pending[i]) begin
              div_act[i] <= div_shadow[i];
              pending[i] <= 1'b0;
            end
          end else begin
            count[i] <= count[i] + WIDTH'(1);
          end
        end else if (pending[i]) begin
          // Idle channel: nothing to glitch, so load right away.
          div_act[i] <= div_shadow[i];
          pending[i] <= 1'b0;
          count[i]   <= '0;
        end
        // A hit implies pending was clear, so no clash with the load above.
        if (hit[i]) begin
          div_shadow[i] <= cfg_div;
          pending[i]    <= 1'b1;
        end
`else
        if (hit[i]) begin
          div_act[i] <= cfg_div;
          count[i]   <= '0;
        end else if (en[i]) begin
          if (count[i] == div_act[i]) begin
            count[i]   <= '0;
            clk_out[i] <= ~clk_out[i];
            tick[i]    <= ~clk_out[i];
          end else begin
            count[i] <= count[i] + WIDTH'(1);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed vectors for clk_div_bank (3 channels, 8-bit, div 3).
// Covers default ratio, div=0, enable hold, divisor loads and reset.
module tb_clk_div_bank;

  localparam int CH = 3;
  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] en = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_chan = '0;
  logic [W-1:0]  cfg_div = '0;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;

  int nvec = 0;
  int nerr = 0;

  always #5 clk_in = ~clk_in;

  clk_div_bank #(
    .CHANNELS(CH),
    .WIDTH(W),
    .DEFAULT_DIV(8'd3)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .en(en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan),
    .cfg_div(cfg_div),
    .clk_out(clk_out),
    .tick(tick)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    en = '0;
    cfg_valid = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic wr_idle(input int chan, input int div);
    cfg_chan = CW'(chan);
    cfg_div = W'(div);
    cfg_valid = 1'b1;
    cyc(1);
    cfg_valid = 1'b0;
    cyc(2);
  endtask

  initial begin
    logic lvl;

    // reset state and default ratio (div 3 -> period 8)
    do_reset;
    chk("rst_clk", 32'(clk_out), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    en = 3'b011;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      lvl = ((k / 4) % 2) == 1;
      chk("dflt_clk", 32'(clk_out), 32'({1'b0, lvl, lvl}));
      chk("dflt_tick", 32'(tick), (k % 8 == 4) ? 32'd3 : 32'd0);
    end

    // div=0 toggles every cycle; enable low freezes
    do_reset;
    wr_idle(0, 0);
    en = 3'b001;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk("div0_clk", 32'(clk_out[0]), 32'(k % 2));
      chk("div0_tick", 32'(tick[0]), 32'(k % 2));
    end
    en = 3'b000;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("hold_clk", 32'(clk_out[0]), 32'd1);
      chk("hold_tick", 32'(tick[0]), 32'd0);
    end
    en = 3'b001;
    cyc();
    chk("resume_clk0", 32'(clk_out[0]), 32'd0);
    cyc();
    chk("resume_clk1", 32'(clk_out[0]), 32'd1);
    chk("resume_tick", 32'(tick[0]), 32'd1);

`ifdef CLK_DIV_BANK_SYNC_LOAD_EN
    // sync load mid-period, back-pressure, collision at terminal
    do_reset;
    wr_idle(1, 5);
    en = 3'b010;
    cyc(2);
    cfg_chan = 2'd1;
    cfg_div = 8'd1;
    cfg_valid = 1'b1;
    chk("sync_rdy0", 32'(cfg_ready), 32'd1);
    cyc();
    cfg_div = 8'd4;
    chk("bp_rdy3", 32'(cfg_ready), 32'd0);
    cyc();
    chk("bp_rdy4", 32'(cfg_ready), 32'd0);
    chk("sync_clk4", 32'(clk_out[1]), 32'd0);
    cyc();
    chk("bp_rdy5", 32'(cfg_ready), 32'd0);
    chk("sync_clk5", 32'(clk_out[1]), 32'd0);
    cfg_valid = 1'b0;
    cyc();
    chk("sync_clk6", 32'(clk_out[1]), 32'd1);
    chk("sync_tick6", 32'(tick[1]), 32'd1);
    cyc();
    chk("sync_tick7", 32'(tick[1]), 32'd0);
    cyc();
    chk("sync_clk8", 32'(clk_out[1]), 32'd0);
    cyc(2);
    chk("sync_clk10", 32'(clk_out[1]), 32'd1);
    chk("sync_tick10", 32'(tick[1]), 32'd1);
    cyc();
    cfg_div = 8'd3;
    cfg_valid = 1'b1;
    chk("col_rdy", 32'(cfg_ready), 32'd1);
    cyc();
    cfg_valid = 1'b0;
    chk("col_clk12", 32'(clk_out[1]), 32'd0);
    cyc(2);
    chk("col_clk14", 32'(clk_out[1]), 32'd1);
    cyc(3);
    chk("col_clk17", 32'(clk_out[1]), 32'd1);
    cyc();
    chk("col_clk18", 32'(clk_out[1]), 32'd0);
`else
    // immediate load restarts count; out-of-range write dropped
    do_reset;
    wr_idle(0, 9);
    en = 3'b001;
    cyc(7);
    cfg_chan = 2'd0;
    cfg_div = 8'd2;
    cfg_valid = 1'b1;
    chk("imm_rdy", 32'(cfg_ready), 32'd1);
    cyc();
    cfg_valid = 1'b0;
    chk("imm_clk8", 32'(clk_out[0]), 32'd0);
    cyc();
    chk("imm_clk9", 32'(clk_out[0]), 32'd0);
    cyc();
    chk("imm_clk10", 32'(clk_out[0]), 32'd0);
    cyc();
    chk("imm_clk11", 32'(clk_out[0]), 32'd1);
    chk("imm_tick11", 32'(tick[0]), 32'd1);
    cfg_chan = 2'd3;
    cfg_div = 8'd0;
    cfg_valid = 1'b1;
    chk("oor_rdy", 32'(cfg_ready), 32'd1);
    cyc();
    cfg_valid = 1'b0;
    chk("oor_clk12", 32'(clk_out), 32'd1);
    cyc();
    chk("oor_clk13", 32'(clk_out), 32'd1);
    cyc();
    chk("oor_clk14", 32'(clk_out), 32'd0);
`endif

    // reset mid-operation with a write outstanding
    do_reset;
    en = 3'b011;
    cyc(4);
    chk("mid_clk4", 32'(clk_out), 32'd3);
    cfg_chan = 2'd1;
    cfg_div = 8'd7;
    cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
`ifdef CLK_DIV_BANK_SYNC_LOAD_EN
    chk("mid_pend", 32'(cfg_ready), 32'd0);
`endif
    rst = 1'b1;
    cyc();
    chk("mid_rst_clk", 32'(clk_out), 32'd0);
    chk("mid_rst_tick", 32'(tick), 32'd0);
    chk("mid_rst_rdy", 32'(cfg_ready), 32'd1);
    rst = 1'b0;
    cyc(3);
    chk("mid_rel_clk3", 32'(clk_out), 32'd0);
    cyc();
    chk("mid_rel_clk4", 32'(clk_out), 32'd3);
    chk("mid_rel_tick4", 32'(tick), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
